// File: rtl/uart_fifo_tx.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a serializer that sends
// queued frames back to back, LSB first, with the line idling high.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (line low) for CLK_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLK_PER_BIT cycles each
// STOP  | stop bit (line high); last cycle pulses tx_done and may pop the next byte
module uart_fifo_tx #(
    parameter int CLK_PER_BIT = 100,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          wr_data,
    input  logic                wr_en,
    output logic                full,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                serial_line
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [2:0]            bit_idx, bit_idx_nxt;
    logic [7:0]            shift, shift_nxt;
    logic                  line_nxt;
    logic                  pop;
    logic                  wr_ok;
    logic                  bit_last;

    // level never exceeds DEPTH, so its MSB alone marks a full FIFO
    assign full     = level[DEPTH_LOG2];
    assign wr_ok    = wr_en && !full;
    assign bit_last = (bit_cnt == CNT_LAST);
    assign tx_busy  = (state != IDLE);
    assign tx_done  = (state == STOP) && bit_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !pop)
                level <= level + 1'b1;
            else if (pop && !wr_ok)
                level <= level - 1'b1;
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pop         = 1'b0;
        line_nxt    = 1'b1;
        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                if (level != '0) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_last) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (bit_last) begin
                    bit_cnt_nxt = '0;
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_last) begin
                    bit_cnt_nxt = '0;
                    // chain straight into the next start bit when data is waiting
                    if (level != '0) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shift_nxt[0];
            default: line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            serial_line <= 1'b1;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shift       <= shift_nxt;
            serial_line <= line_nxt;
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx: instance A (4 clocks/bit) for frame-level
// checks, instance B (10 clocks/bit) for a 256-byte loopback through a line decoder.
module tb_uart_fifo_tx;
    localparam int CPB_A = 4;
    localparam int CPB_B = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data_a, wr_data_b;
    logic       wr_en_a, wr_en_b;
    logic       full_a, full_b;
    logic [4:0] level_a, level_b;
    logic       ovf_a, ovf_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic       line_a, line_b;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    uart_fifo_tx #(.CLK_PER_BIT(CPB_A), .DEPTH_LOG2(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data_a), .wr_en(wr_en_a),
        .full(full_a), .level(level_a), .overflow(ovf_a), .tx_busy(busy_a),
        .tx_done(done_a), .serial_line(line_a)
    );

    uart_fifo_tx #(.CLK_PER_BIT(CPB_B), .DEPTH_LOG2(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data_b), .wr_en(wr_en_b),
        .full(full_b), .level(level_b), .overflow(ovf_b), .tx_busy(busy_b),
        .tx_done(done_b), .serial_line(line_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Line decoder: finds the start-bit fall, samples mid-bit, checks the stop bit.
    int         cyc = 0;
    int         cpb_v [2] = '{CPB_A, CPB_B};
    bit         mon_act [2];
    bit         mon_prev [2] = '{1'b1, 1'b1};
    int         mon_pos [2];
    logic [9:0] mon_sh [2];
    int         done_cnt [2];
    int         frame_err [2];
    logic [7:0] rx_q0 [$];
    logic [7:0] rx_q1 [$];
    int         starts_a [$];

    always @(negedge clk) begin
        logic ln;
        logic dn;
        int   j;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            ln = (k == 0) ? line_a : line_b;
            dn = (k == 0) ? done_a : done_b;
            if (!rst_n) begin
                mon_act[k]  = 1'b0;
                mon_prev[k] = 1'b1;
            end else begin
                if (dn) done_cnt[k]++;
                if (!mon_act[k]) begin
                    if (mon_prev[k] && !ln) begin
                        mon_act[k] = 1'b1;
                        mon_pos[k] = 0;
                        if (k == 0) starts_a.push_back(cyc);
                    end
                end else begin
                    mon_pos[k]++;
                end
                if (mon_act[k] && (mon_pos[k] % cpb_v[k]) == cpb_v[k] / 2) begin
                    j = mon_pos[k] / cpb_v[k];
                    mon_sh[k][j] = ln;
                    if (j == 9) begin
                        mon_act[k] = 1'b0;
                        if (!ln || mon_sh[k][0])
                            frame_err[k]++;
                        else if (k == 0)
                            rx_q0.push_back(mon_sh[k][8:1]);
                        else
                            rx_q1.push_back(mon_sh[k][8:1]);
                    end
                end
                mon_prev[k] = ln;
            end
        end
    end

    task automatic wait_idle(input string tag, input bit sel, input int limit);
        int n = 0;
        while ((sel ? (busy_b || level_b != 0) : (busy_a || level_a != 0)) && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < limit), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_frame;
        logic [7:0] sent [$];
        int         d0, n, bad, peak, lows;

        rst_n = 1'b0;
        wr_en_a = 1'b0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_data_b = '0;
        repeat (3) tick();
        chk("rst_line", line_a, 1);
        chk("rst_level", level_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        rst_n = 1'b1;
        tick();

        // single byte 0xA3: start, 1100_0101 LSB first, stop
        d0 = done_cnt[0];
        exp_frame = 10'b1_1010_0011_0;
        wr_en_a = 1'b1; wr_data_a = 8'hA3;
        tick();
        wr_en_a = 1'b0;
        chk("single_level1", level_a, 1);
        chk("single_line_n", line_a, 1);
        tick();
        chk("single_busy", busy_a, 1);
        for (int c = 0; c < 40; c++) begin
            chk($sformatf("single_bit_c%0d", c), line_a, exp_frame[c / 4]);
            chk($sformatf("single_done_c%0d", c), done_a, 32'(c == 39));
            tick();
        end
        chk("single_idle_busy", busy_a, 0);
        chk("single_idle_line", line_a, 1);
        chk("single_rx_cnt", rx_q0.size(), 1);
        if (rx_q0.size() > 0) chk("single_rx_byte", rx_q0[0], 8'hA3);
        chk("single_done_cnt", done_cnt[0] - d0, 1);
        rx_q0.delete();

        // reset in the middle of a DATA bit with a second byte queued
        wr_en_a = 1'b1; wr_data_a = 8'h55;
        tick();
        wr_data_a = 8'h66;
        tick();
        wr_en_a = 1'b0;
        repeat (8) tick();
        chk("midrst_pre_busy", busy_a, 1);
        chk("midrst_pre_level", level_a, 1);
        rst_n = 1'b0;
        tick();
        chk("midrst_line", line_a, 1);
        chk("midrst_level", level_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        rst_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (!line_a || busy_a) lows++;
        end
        chk("midrst_no_frames", lows, 0);
        chk("midrst_rx_cnt", rx_q0.size(), 0);
        rx_q0.delete();
        starts_a.delete();

        // burst of 16 on consecutive cycles; head pops after the first write
        d0 = done_cnt[0];
        peak = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en_a = 1'b1; wr_data_a = 8'(i);
            tick();
            if (level_a > peak) peak = level_a;
        end
        wr_en_a = 1'b0;
        chk("burst_level", level_a, 15);
        chk("burst_peak", peak, 15);
        chk("burst_full", full_a, 0);
        wait_idle("burst_drain_timeout", 1'b0, 800);
        chk("burst_starts", starts_a.size(), 16);
        bad = 0;
        for (int i = 1; i < starts_a.size(); i++)
            if (starts_a[i] - starts_a[i-1] != 40) bad++;
        chk("burst_gap40", bad, 0);
        chk("burst_done_cnt", done_cnt[0] - d0, 16);
        chk("burst_rx_cnt", rx_q0.size(), 16);
        for (int i = 0; i < rx_q0.size() && i < 16; i++)
            chk($sformatf("burst_rx_%0d", i), rx_q0[i], i);
        rx_q0.delete();

        // overflow: 17 writes fill the FIFO, then a write lands on the pop cycle
        for (int i = 0; i < 17; i++) begin
            wr_en_a = 1'b1; wr_data_a = 8'(8'h20 + i);
            tick();
        end
        wr_en_a = 1'b0;
        chk("ovf_full", full_a, 1);
        chk("ovf_level16", level_a, 16);
        n = 0;
        while (!done_a && n < 100) begin
            tick();
            n++;
        end
        chk("ovf_align_done", done_a, 1);
        chk("ovf_pre_ovf", ovf_a, 0);
        wr_en_a = 1'b1; wr_data_a = 8'hEE;
        tick();
        wr_en_a = 1'b0;
        chk("ovf_flag", ovf_a, 1);
        chk("ovf_level15", level_a, 15);
        chk("ovf_full_clr", full_a, 0);
        wait_idle("ovf_drain_timeout", 1'b0, 1000);
        chk("ovf_rx_cnt", rx_q0.size(), 17);
        for (int i = 0; i < rx_q0.size() && i < 17; i++)
            chk($sformatf("ovf_rx_%0d", i), rx_q0[i], 8'h20 + i);
        chk("ovf_sticky", ovf_a, 1);
        rx_q0.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ovf_rst_clr", ovf_a, 0);

        // wrap-around: 8 up front, then one write per frame time
        sent.delete();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            wr_en_a = 1'b1; wr_data_a = 8'((i * 37 + 5) & 8'hFF);
            sent.push_back(wr_data_a);
            tick();
            wr_en_a = 1'b0;
            if (level_a < 1 || level_a > 15) bad++;
            if (i >= 7) repeat (39) tick();
        end
        chk("wrap_level_range", bad, 0);
        wait_idle("wrap_drain_timeout", 1'b0, 1000);
        chk("wrap_ovf", ovf_a, 0);
        chk("wrap_rx_cnt", rx_q0.size(), 40);
        for (int i = 0; i < rx_q0.size() && i < 40; i++)
            chk($sformatf("wrap_rx_%0d", i), rx_q0[i], sent[i]);
        chk("a_frame_err", frame_err[0], 0);

        // loopback on instance B: all 256 values in 64-byte bursts, flow-controlled by full
        d0 = done_cnt[1];
        for (int b = 0; b < 256; b++) begin
            n = 0;
            while (full_b && n < 2000) begin
                wr_en_b = 1'b0;
                tick();
                n++;
            end
            wr_en_b = 1'b1; wr_data_b = 8'(b);
            tick();
            if (b % 64 == 63) begin
                wr_en_b = 1'b0;
                wait_idle($sformatf("loop_drain_timeout_%0d", b / 64), 1'b1, 8000);
            end
        end
        wr_en_b = 1'b0;
        chk("loop_rx_cnt", rx_q1.size(), 256);
        for (int i = 0; i < rx_q1.size() && i < 256; i++)
            chk($sformatf("loop_rx_%0d", i), rx_q1[i], i);
        chk("loop_done_cnt", done_cnt[1] - d0, 256);
        chk("loop_ovf", ovf_b, 0);
        chk("b_frame_err", frame_err[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
